// File: rtl/feed_forward_pkg.sv
// rtl/feed_forward_pkg.sv - shared types and defaults for the feed-forward sequencer
package feed_forward_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_NEXT  = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } state_t;

    // Shared with the layer-engine top so both agree on network shape.
    localparam int         DEFAULT_NUM_LAYERS     = 3;
    localparam logic [2:0] DEFAULT_LEAKYRELU_MASK = 3'b011;

endpackage

// File: rtl/feed_forward_sequencer_if.sv
// rtl/feed_forward_sequencer_if.sv - handshake bundle between DQN control, sequencer and layer engines
interface feed_forward_sequencer_if #(
    parameter int NUM_LAYERS      = 3,
    parameter int LAYER_IDX_WIDTH = 2,
    parameter int CNT_WIDTH       = 32
) ();

    logic                       i_valid;
    logic                       o_ready;
    logic [NUM_LAYERS-1:0]      i_layer_done;
    logic                       i_abort;
    logic [NUM_LAYERS-1:0]      o_layer_start;
    logic [LAYER_IDX_WIDTH-1:0] o_layer_idx;
    logic                       o_relu_en;
    logic                       o_bank_sel;
    logic                       o_busy;
    logic                       o_valid;
    logic                       o_error;
    logic [CNT_WIDTH-1:0]       o_cycle_count;

    // Sequencer side
    modport master (
        input  i_valid, i_layer_done, i_abort,
        output o_ready, o_layer_start, o_layer_idx, o_relu_en, o_bank_sel,
               o_busy, o_valid, o_error, o_cycle_count
    );

    // Requester / engine side
    modport slave (
        output i_valid, i_layer_done, i_abort,
        input  o_ready, o_layer_start, o_layer_idx, o_relu_en, o_bank_sel,
               o_busy, o_valid, o_error, o_cycle_count
    );

endinterface

// File: rtl/layer_watchdog.sv
// rtl/layer_watchdog.sv - per-layer timeout counter with expiry flag
module layer_watchdog #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT_CYCLES + 1);

    logic [W-1:0] count;

    // Count enabled cycles since the last clear, saturating so it never wraps.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

    // Expiry fires during the TIMEOUT_CYCLES-th enabled cycle (count starts at 0).
    assign expired = enable && (count >= W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/feed_forward_sequencer.sv
// rtl/feed_forward_sequencer.sv - start/done sequencer for an N-layer feed-forward inference
module feed_forward_sequencer
    import feed_forward_pkg::*;
#(
    parameter int                    NUM_LAYERS      = DEFAULT_NUM_LAYERS,
    parameter int                    LAYER_IDX_WIDTH = 2,
    parameter logic [NUM_LAYERS-1:0] LEAKYRELU_MASK  = DEFAULT_LEAKYRELU_MASK,
    parameter int                    TIMEOUT_CYCLES  = 65535,
    parameter int                    CNT_WIDTH       = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    feed_forward_sequencer_if.master bus
);

    state_t                     state;
    state_t                     state_next;
    logic [LAYER_IDX_WIDTH-1:0] idx;
    logic [CNT_WIDTH-1:0]       cycle_count;
    logic                       wd_expired;
    logic                       last_layer;
    logic                       own_done;
    logic                       accept;

    assign last_layer = (idx == LAYER_IDX_WIDTH'(NUM_LAYERS - 1));
    assign own_done   = bus.i_layer_done[idx];
    assign accept     = (state == ST_IDLE) && bus.i_valid;

    layer_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (state == ST_START),
        .enable (state == ST_WAIT),
        .expired(wd_expired)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: own done beats the watchdog, abort beats everything but reset.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (bus.i_valid) state_next = ST_START;
            ST_START: state_next = ST_WAIT;
            ST_WAIT: begin
                if (own_done) begin
                    state_next = last_layer ? ST_DONE : ST_NEXT;
                end else if (wd_expired) begin
                    state_next = ST_ERROR;
                end
            end
            ST_NEXT:  state_next = ST_START;
            ST_DONE:  state_next = ST_IDLE;
            ST_ERROR: state_next = ST_ERROR;
            default:  state_next = ST_IDLE;
        endcase
        if (bus.i_abort && (state != ST_IDLE)) begin
            state_next = ST_IDLE;
        end
    end

    // Layer index and latency counter; the counter freezes in IDLE and ERROR.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx         <= '0;
            cycle_count <= '0;
        end else if (accept) begin
            idx         <= '0;
            cycle_count <= '0;
        end else begin
            if (state == ST_NEXT) begin
                idx <= idx + LAYER_IDX_WIDTH'(1);
            end
            if ((state != ST_IDLE) && (state != ST_ERROR) && (cycle_count != {CNT_WIDTH{1'b1}})) begin
                cycle_count <= cycle_count + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.o_ready       = (state == ST_IDLE);
    assign bus.o_busy        = (state != ST_IDLE);
    assign bus.o_valid       = (state == ST_DONE);
    assign bus.o_error       = (state == ST_ERROR);
    assign bus.o_layer_start = (state == ST_START) ? (NUM_LAYERS'(1) << idx) : '0;
    assign bus.o_layer_idx   = idx;
    assign bus.o_relu_en     = LEAKYRELU_MASK[idx];
    assign bus.o_bank_sel    = idx[0];
    assign bus.o_cycle_count = cycle_count;

endmodule

// File: tb/tb_feed_forward_sequencer.sv
// tb/tb_feed_forward_sequencer.sv - self-checking bench for feed_forward_sequencer
module tb_feed_forward_sequencer;

    localparam int A_TO = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] mask_a = 3'b011;
    int         n_cmp = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    feed_forward_sequencer_if #(.NUM_LAYERS(3), .LAYER_IDX_WIDTH(2), .CNT_WIDTH(32)) a_bus ();
    feed_forward_sequencer_if #(.NUM_LAYERS(1), .LAYER_IDX_WIDTH(1), .CNT_WIDTH(2))  b_bus ();

    feed_forward_sequencer #(
        .NUM_LAYERS(3), .LAYER_IDX_WIDTH(2), .LEAKYRELU_MASK(3'b011),
        .TIMEOUT_CYCLES(A_TO), .CNT_WIDTH(32)
    ) dut_a (.clk(clk), .rst(rst), .bus(a_bus));

    feed_forward_sequencer #(
        .NUM_LAYERS(1), .LAYER_IDX_WIDTH(1), .LEAKYRELU_MASK(1'b1),
        .TIMEOUT_CYCLES(A_TO), .CNT_WIDTH(2)
    ) dut_b (.clk(clk), .rst(rst), .bus(b_bus));

    // One expected cycle of an inference on the 3-layer instance.
    typedef struct {
        logic [2:0]  start;
        logic [1:0]  idx;
        bit          valid;
        bit          err;
        bit          drive_done;
        bit          abort;
        bit          rst_pulse;
        logic [31:0] cnt;
    } step_t;

    step_t tl[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference timeline: each layer costs START + lat WAIT cycles + NEXT/DONE;
    // a layer whose done never comes within A_TO WAIT cycles lands in ERROR.
    task automatic build(input int l0, input int l1, input int l2, input bit abort_last,
                         input bit rst_mid, output logic [31:0] fcnt, output bit fin_rst);
        int          lat[3];
        step_t       s;
        logic [31:0] c;
        bit          stop;
        lat = '{l0, l1, l2};
        tl.delete();
        c = 0;
        stop = 0;
        fin_rst = 0;
        for (int j = 0; j < 3 && !stop; j++) begin
            s = '{default: 0};
            s.start = 3'(1 << j); s.idx = 2'(j); s.cnt = c;
            tl.push_back(s); c++;
            for (int k = 1; k <= A_TO && k <= lat[j] && !stop; k++) begin
                s = '{default: 0};
                s.idx = 2'(j); s.cnt = c; s.drive_done = (k == lat[j]);
                if (rst_mid && j == 1 && k == 2) begin s.rst_pulse = 1; stop = 1; fin_rst = 1; end
                if (abort_last && j == 2 && k == lat[j]) begin s.abort = 1; stop = 1; end
                tl.push_back(s); c++;
            end
            if (!stop && lat[j] > A_TO) begin
                int n;
                n = $urandom_range(5, 2);
                for (int e = 0; e < n; e++) begin
                    s = '{default: 0};
                    s.idx = 2'(j); s.err = 1; s.cnt = c; s.abort = (e == n - 1);
                    tl.push_back(s);
                end
                stop = 1;
            end
            if (!stop) begin
                s = '{default: 0};
                s.idx = 2'(j); s.cnt = c; s.valid = (j == 2);
                tl.push_back(s); c++;
            end
        end
        fcnt = fin_rst ? 32'd0 : c;
    endtask

    // noise: 0 = other done bits low, 1 = random, 2 = held high.
    task automatic run_a(input int l0, input int l1, input int l2, input int noise,
                         input bit abort_last, input bit rst_mid, input bit spam, input string tag);
        logic [31:0] fc;
        bit          fr;
        logic [2:0]  dv;
        build(l0, l1, l2, abort_last, rst_mid, fc, fr);
        @(posedge clk); #1;
        a_bus.i_valid = 1'b1; a_bus.i_layer_done = '0; a_bus.i_abort = 1'b0;
        @(negedge clk);
        check({tag, "_accept_ready"}, a_bus.o_ready, 1);
        foreach (tl[i]) begin
            @(posedge clk); #1;
            a_bus.i_valid = spam ? 1'($urandom) : 1'b0;
            dv = (noise == 0) ? 3'b000 : (noise == 1) ? 3'($urandom) : 3'b111;
            dv[tl[i].idx] = tl[i].drive_done;
            a_bus.i_layer_done = dv;
            a_bus.i_abort = tl[i].abort;
            rst = tl[i].rst_pulse;
            @(negedge clk);
            check({tag, "_start"}, a_bus.o_layer_start, tl[i].start);
            check({tag, "_idx"},   a_bus.o_layer_idx, tl[i].idx);
            check({tag, "_relu"},  a_bus.o_relu_en, mask_a[tl[i].idx]);
            check({tag, "_bank"},  a_bus.o_bank_sel, tl[i].idx % 2);
            check({tag, "_busy"},  a_bus.o_busy, 1);
            check({tag, "_ready"}, a_bus.o_ready, 0);
            check({tag, "_valid"}, a_bus.o_valid, tl[i].valid);
            check({tag, "_error"}, a_bus.o_error, tl[i].err);
            check({tag, "_cnt"},   a_bus.o_cycle_count, tl[i].cnt);
        end
        @(posedge clk); #1;
        a_bus.i_valid = 1'b0; a_bus.i_layer_done = '0; a_bus.i_abort = 1'b0; rst = 1'b0;
        @(negedge clk);
        check({tag, "_end_ready"}, a_bus.o_ready, 1);
        check({tag, "_end_busy"},  a_bus.o_busy, 0);
        check({tag, "_end_valid"}, a_bus.o_valid, 0);
        check({tag, "_end_error"}, a_bus.o_error, 0);
        check({tag, "_end_start"}, a_bus.o_layer_start, 0);
        check({tag, "_end_cnt"},   a_bus.o_cycle_count, fc);
        if (fr) begin
            check({tag, "_rst_idx"},  a_bus.o_layer_idx, 0);
            check({tag, "_rst_relu"}, a_bus.o_relu_en, mask_a[0]);
            check({tag, "_rst_bank"}, a_bus.o_bank_sel, 0);
        end
    endtask

    // Single-layer instance: i_valid held high while busy must not retrigger.
    task automatic run_b(input int lat, input string tag);
        int starts;
        int vcyc;
        int exp_cnt;
        starts = 0;
        vcyc = -1;
        exp_cnt = (lat + 2 > 3) ? 3 : lat + 2;
        @(posedge clk); #1;
        b_bus.i_valid = 1'b1; b_bus.i_layer_done = 1'b0;
        @(negedge clk);
        check({tag, "_accept_ready"}, b_bus.o_ready, 1);
        for (int t = 1; t <= lat + 3; t++) begin
            @(posedge clk); #1;
            b_bus.i_valid = (t <= lat + 2);
            b_bus.i_layer_done = (t == lat + 1);
            @(negedge clk);
            if (b_bus.o_layer_start == 1'b1) starts++;
            if (b_bus.o_valid) vcyc = t;
        end
        check({tag, "_starts"},    starts, 1);
        check({tag, "_valid_cyc"}, vcyc, lat + 2);
        check({tag, "_end_ready"}, b_bus.o_ready, 1);
        check({tag, "_end_cnt"},   b_bus.o_cycle_count, exp_cnt);
        @(posedge clk); #1;
        b_bus.i_valid = 1'b0;
    endtask

    initial begin
        a_bus.i_valid = 1'b0; a_bus.i_layer_done = '0; a_bus.i_abort = 1'b0;
        b_bus.i_valid = 1'b0; b_bus.i_layer_done = '0; b_bus.i_abort = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready", a_bus.o_ready, 1);
        check("rst_start", a_bus.o_layer_start, 0);
        check("rst_idx",   a_bus.o_layer_idx, 0);
        check("rst_relu",  a_bus.o_relu_en, mask_a[0]);
        check("rst_bank",  a_bus.o_bank_sel, 0);
        check("rst_busy",  a_bus.o_busy, 0);
        check("rst_valid", a_bus.o_valid, 0);
        check("rst_error", a_bus.o_error, 0);
        check("rst_cnt",   a_bus.o_cycle_count, 0);
        check("rst_b_ready", b_bus.o_ready, 1);
        check("rst_b_cnt",   b_bus.o_cycle_count, 0);

        // Abort in IDLE does nothing.
        @(posedge clk); #1 a_bus.i_abort = 1'b1;
        @(negedge clk);
        @(posedge clk); #1 a_bus.i_abort = 1'b0;
        @(negedge clk);
        check("idle_abort_ready", a_bus.o_ready, 1);
        check("idle_abort_busy",  a_bus.o_busy, 0);

        run_a(1, 1, 1, 0, 0, 0, 0, "seq111");
        run_a(3, 2, 4, 2, 0, 0, 0, "hold_other");
        run_a(2, 99, 1, 1, 0, 0, 1, "timeout");
        run_a(1, 1, 1, 0, 1, 0, 0, "abort_last");
        run_a(2, 3, 1, 0, 0, 1, 0, "rst_mid");
        run_a(1, 2, 1, 0, 0, 0, 0, "after_rst");
        run_a(8, 8, 8, 1, 0, 0, 1, "max_lat");

        for (int r = 0; r < 25; r++) begin
            run_a($urandom_range(9, 1), $urandom_range(9, 1), $urandom_range(9, 1),
                  $urandom_range(2, 0), ($urandom_range(3, 0) == 0), 1'b0,
                  1'($urandom), "rand");
        end

        run_b(1, "one_layer");
        run_b(4, "one_layer_sat");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/feed_forward_sequencer.md
# feed_forward_sequencer

Parametrised controller that runs an N-layer feed-forward inference by starting layer engines one at a time over a start/done handshake, instead of hard-chaining fixed valid pulses. It sits between the DQN top-level control and the layer engine instances. It selects the ping-pong data bank and per-layer activation mode, guards each layer with a watchdog, supports abort, and reports inference latency.

## Interface
- NUM_LAYERS, 3, number of layer engines sequenced (≥1)
- LAYER_IDX_WIDTH, 2, width of layer index; ≥ ceil(log2(NUM_LAYERS)), min 1
- LEAKYRELU_MASK, 3'b011, bit i = LeakyReLU enabled for layer i; width NUM_LAYERS
- TIMEOUT_CYCLES, 65535, max WAIT cycles per layer before error
- CNT_WIDTH, 32, cycle-counter width
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- i_valid  in  1  inference request; accepted only when o_ready=1
- o_ready  out  1  high in IDLE only
- i_layer_done  in  NUM_LAYERS  per-layer completion pulse
- i_abort  in  1  cancel current inference / clear error
- o_layer_start  out  NUM_LAYERS  one-hot, one-cycle start pulse to layer engine
- o_layer_idx  out  LAYER_IDX_WIDTH  layer currently active
- o_relu_en  out  1  LEAKYRELU_MASK[o_layer_idx]
- o_bank_sel  out  1  o_layer_idx[0]; layer reads bank o_bank_sel, writes the other
- o_busy  out  1  state ≠ IDLE
- o_valid  out  1  one-cycle inference-complete pulse
- o_error  out  1  watchdog expired; sticky
- o_cycle_count  out  CNT_WIDTH  latency of last/current inference

## Operation
- States: IDLE, START, WAIT, NEXT, DONE, ERROR. Outputs are Moore decodes of registered state, layer index, and counters.
- IDLE: o_ready=1. i_valid → START; layer index=0; cycle count=0.
- START: o_layer_start[idx]=1 for exactly one cycle; watchdog=0 → WAIT.
- WAIT:
  - i_layer_done[idx]=1 → DONE if idx=NUM_LAYERS-1, else NEXT.
  - Done bits of other layers are ignored.
  - Watchdog increments each cycle. Reaching TIMEOUT_CYCLES without done → ERROR.
- NEXT: idx+1 → START.
- DONE: o_valid=1 → IDLE.
- ERROR: o_error=1, o_busy=1, o_ready=0. Held until i_abort or rst.
- Abort: i_abort in any non-IDLE state → IDLE next cycle, with no o_valid and o_error cleared. Abort beats done/timeout in the same cycle. i_abort in IDLE is a no-op.
- Reset beats everything.
- i_valid outside IDLE is ignored, not queued.
- Cycle counter:
  - Increments in every non-IDLE, non-ERROR state, including the DONE cycle.
  - Saturates at all-ones.
  - Holds its value in IDLE and ERROR until the next accepted i_valid.
- NUM_LAYERS=1: START→WAIT→DONE; NEXT is never entered.

## Timing
- Reset values: o_ready=1; o_layer_start=0; o_layer_idx=0; o_relu_en=LEAKYRELU_MASK[0]; o_bank_sel=0; o_busy=0; o_valid=0; o_error=0; o_cycle_count=0.
- i_valid accepted at cycle T → o_layer_start[0] high at T+1.
- Done in WAIT at cycle D:
  - Non-last layer: NEXT at D+1, next start pulse at D+2.
  - Last layer: o_valid at D+1, o_ready at D+2.
- Done may arrive in the first WAIT cycle, so the minimum layer cost is 3 cycles (START, WAIT, NEXT).
- Minimum inference cost is 3·NUM_LAYERS cycles: for the last layer, DONE replaces NEXT. o_cycle_count then equals 3·NUM_LAYERS.
- Timeout: with no done, ERROR is entered TIMEOUT_CYCLES+1 cycles after the start pulse.

## Structure
- feed_forward_pkg holds:
  - state enum (3-bit)
  - default NUM_LAYERS / LEAKYRELU_MASK constants shared with the layer-engine top
- Sub-module layer_watchdog holds the clearable counter, the TIMEOUT_CYCLES compare, and the expired flag.
- The FSM, index counter, and cycle counter stay in feed_forward_sequencer.

## Test plan
- 3 layers, each done returned 1 cycle into WAIT → starts at T+1, T+4, T+7; o_valid at T+9; o_cycle_count=9; o_relu_en 1,1,0; o_bank_sel 0,1,0.
- Done held on layer 2 while layer 0 active → ignored; layer 0 still waits for its own done.
- TIMEOUT_CYCLES=8, layer 1 never done → o_error high 9 cycles after its start; i_valid ignored; i_abort → IDLE, o_error=0, o_ready=1.
- i_abort same cycle as last-layer done → no o_valid; IDLE next cycle.
- rst asserted mid-WAIT of layer 1 → all outputs return to reset values next cycle; a new i_valid restarts at layer 0.
- NUM_LAYERS=1, i_valid asserted while busy → ignored; single start pulse; o_valid 3 cycles after acceptance; o_cycle_count=3.
